// File: rtl/sipo_rx_pkg.sv
// Shared definitions for the sipo_rx serial receiver: default word width,
// shift FSM states and the bit-counter width helper.
package sipo_rx_pkg;

  localparam int unsigned DEF_WIDTH = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Counter wide enough to hold 0..w
  function automatic int unsigned CNT_W(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Serial datapath for sipo_rx: MSB-first shift register, bit counter and
// frame FSM with sync/sin_en handling; flags each completed word.
module sipo_shift_core
  import sipo_rx_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin,
  input  logic             sin_en,
  input  logic             sync,
  output logic [WIDTH-1:0] word,
  output logic             word_done,
  output logic             busy
);

  localparam int unsigned CW = CNT_W(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t          state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]   cnt;

  // The completing bit is visible combinationally so the holding register
  // loads on the same edge that samples it; sync always starts a new frame.
  assign word      = {shreg[WIDTH-2:0], sin};
  assign word_done = sin_en & ~sync & (state == ST_SHIFT) & (cnt == LAST);
  assign busy      = (cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else if (sync) begin
      if (sin_en) begin
        shreg <= {{(WIDTH-1){1'b0}}, sin};
        cnt   <= CW'(1);
        state <= ST_SHIFT;
      end else begin
        shreg <= '0;
        cnt   <= '0;
        state <= ST_IDLE;
      end
    end else if (sin_en) begin
      shreg <= word;
      case (state)
        ST_IDLE: begin
          cnt   <= CW'(1);
          state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          cnt   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/sipo_rx.sv
// Serial-in parallel-out receiver: double-buffered word output with
// valid/ready handshake and a sticky overrun flag.
module sipo_rx
  import sipo_rx_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin,
  input  logic             sin_en,
  input  logic             sync,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             overrun,
  input  logic             ovr_clr
);

  logic [WIDTH-1:0] word;
  logic             word_done;
  logic             consume;
  logic             can_load;

  sipo_shift_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .sin       (sin),
    .sin_en    (sin_en),
    .sync      (sync),
    .word      (word),
    .word_done (word_done),
    .busy      (busy)
  );

  assign consume  = dout_valid & dout_ready;
  assign can_load = ~dout_valid | dout_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (word_done && can_load) begin
      dout       <= word;
      dout_valid <= 1'b1;
    end else if (consume) begin
      dout_valid <= 1'b0;
    end
  end

  // A new drop in the same cycle as ovr_clr must leave the flag set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (word_done && !can_load) begin
      overrun <= 1'b1;
    end else if (ovr_clr) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sipo_rx.sv
// Directed bench for sipo_rx (WIDTH=4) with a queue of expected words.
module tb_sipo_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sin, sin_en, sync;
  logic [3:0] dout;
  logic       dout_valid, dout_ready;
  logic       busy, overrun, ovr_clr;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [3:0]  exp_q[$];

  sipo_rx #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sin        (sin),
    .sin_en     (sin_en),
    .sync       (sync),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy),
    .overrun    (overrun),
    .ovr_clr    (ovr_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled there too
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    sin    = b;
    sin_en = 1'b1;
    tick();
    sin_en = 1'b0;
    sin    = 1'b0;
  endtask

  task automatic send_word(input logic [3:0] w);
    for (int i = 3; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic check_word(input string tag);
    logic [3:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL %s: observed=%0h expected=<empty scoreboard>", tag, dout);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_valid"}, {31'd0, dout_valid}, 32'd1);
      check({tag, "_dout"}, {28'd0, dout}, {28'd0, e});
    end
  endtask

  task automatic consume_one();
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; sin = 1'b0; sin_en = 1'b0; sync = 1'b0;
    dout_ready = 1'b0; ovr_clr = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("rst_dout", {28'd0, dout}, 32'd0);
    check("rst_valid", {31'd0, dout_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ovr", {31'd0, overrun}, 32'd0);

    // Held word plus a dropped word, then reset mid-frame
    exp_q.push_back(4'b0111);
    send_word(4'b0111);
    check_word("held");
    send_word(4'b1110);
    check("pre_rst_ovr", {31'd0, overrun}, 32'd1);
    send_bit(1'b1);
    send_bit(1'b1);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_dout", {28'd0, dout}, 32'd0);
    check("arst_valid", {31'd0, dout_valid}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_ovr", {31'd0, overrun}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    exp_q.push_back(4'b1001);
    send_word(4'b1001);
    check_word("post_rst");
    consume_one();
    check("post_rst_drain", {31'd0, dout_valid}, 32'd0);

    // Basic word, valid appears only after the fourth bit
    exp_q.push_back(4'b1011);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    check("basic_not_yet", {31'd0, dout_valid}, 32'd0);
    send_bit(1'b1);
    check_word("basic");
    check("basic_busy", {31'd0, busy}, 32'd0);
    consume_one();
    check("basic_drain", {31'd0, dout_valid}, 32'd0);

    // Gapped bits
    exp_q.push_back(4'b0110);
    begin
      logic [3:0] gw;
      gw = 4'b0110;
      for (int i = 3; i >= 0; i--) begin
        send_bit(gw[i]);
        if (i != 0) begin
          for (int g = 0; g < 3; g++) begin
            check("gap_busy", {31'd0, busy}, 32'd1);
            check("gap_valid", {31'd0, dout_valid}, 32'd0);
            tick();
          end
        end
      end
    end
    check_word("gapped");
    consume_one();

    // Backpressure and overrun
    exp_q.push_back(4'b1011);
    send_word(4'b1011);
    send_word(4'b0110);
    check("bp_ovr", {31'd0, overrun}, 32'd1);
    check("bp_hold_dout", {28'd0, dout}, 32'hb);
    // Set wins over a coincident clear
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
    ovr_clr = 1'b1;
    send_bit(1'b1);
    ovr_clr = 1'b0;
    check("set_beats_clr", {31'd0, overrun}, 32'd1);
    check_word("bp_word");
    consume_one();
    check("bp_drain", {31'd0, dout_valid}, 32'd0);
    check("bp_ovr_sticky", {31'd0, overrun}, 32'd1);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    check("ovr_clr", {31'd0, overrun}, 32'd0);

    // Continuous ready, back-to-back frames
    dout_ready = 1'b1;
    exp_q.push_back(4'b1100);
    exp_q.push_back(4'b0011);
    send_word(4'b1100);
    check_word("b2b_first");
    send_word(4'b0011);
    check_word("b2b_second");
    check("b2b_ovr", {31'd0, overrun}, 32'd0);
    tick();
    check("b2b_drain", {31'd0, dout_valid}, 32'd0);
    dout_ready = 1'b0;

    // Consume and complete in the same cycle keeps valid high
    exp_q.push_back(4'b1010);
    exp_q.push_back(4'b0101);
    send_word(4'b1010);
    check_word("same_first");
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    dout_ready = 1'b1;
    send_bit(1'b1);
    dout_ready = 1'b0;
    check_word("same_second");
    check("same_ovr", {31'd0, overrun}, 32'd0);
    consume_one();

    // Sync with no bit aborts the partial frame
    exp_q.push_back(4'b0101);
    send_bit(1'b1); send_bit(1'b1);
    sync = 1'b1;
    tick();
    sync = 1'b0;
    check("sync_busy", {31'd0, busy}, 32'd0);
    send_word(4'b0101);
    check_word("sync_idle");
    consume_one();
    tick(); tick();
    check("sync_one_word", {31'd0, dout_valid}, 32'd0);

    // Sync coincident with the first bit of the new frame
    exp_q.push_back(4'b0101);
    send_bit(1'b1); send_bit(1'b1);
    sync = 1'b1;
    send_bit(1'b0);
    sync = 1'b0;
    check("sync_bit_busy", {31'd0, busy}, 32'd1);
    send_bit(1'b1); send_bit(1'b0);
    check("sync_bit_not_yet", {31'd0, dout_valid}, 32'd0);
    send_bit(1'b1);
    check_word("sync_bit");
    consume_one();
    tick(); tick();
    check("sync_bit_one_word", {31'd0, dout_valid}, 32'd0);
    check("sb_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
